// File: rtl/multicore_pkg.sv
// multicore_pkg: shared types and defaults for the job dispatcher and its arbiter
package multicore_pkg;
    localparam int CORES_DEF = 4;
    typedef logic [7:0] word_t;
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/job_dispatcher_if.sv
// job_dispatcher_if: start/req/ack handshake, job window and run status
interface job_dispatcher_if import multicore_pkg::*; #(parameter int CORES = CORES_DEF) ();
    logic             start;
    logic [CORES-1:0] req;
    logic [CORES-1:0] ack;
    word_t            job_lo;
    word_t            job_hi;
    logic             exhausted;
    logic             done;
    word_t            jobs_issued;
    logic [15:0]      run_cycles;
    modport master (output start, req, input ack, job_lo, job_hi, exhausted, done, jobs_issued, run_cycles);
    modport slave (input start, req, output ack, job_lo, job_hi, exhausted, done, jobs_issued, run_cycles);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching from the index after the last grant
module rr_arbiter import multicore_pkg::*; #(
    parameter int N  = CORES_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt
);
    logic [IW-1:0] w_idx;
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(i_last) + k) % N);
            if (o_gnt == '0 && i_elig[w_idx]) o_gnt[w_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/job_dispatcher.sv
// job_dispatcher: hands out CHUNK-sized slices of 0..RANGE_END to idle cores round-robin
module job_dispatcher import multicore_pkg::*; #(
    parameter int CORES     = CORES_DEF,
    parameter int RANGE_END = 255,
    parameter int CHUNK     = 16
) (
    input logic            clk,
    input logic            reset,
    job_dispatcher_if.slave bus
);
    localparam int         IW   = idx_w(CORES);
    localparam logic [8:0] END9 = 9'(RANGE_END);
    localparam logic [8:0] STEP = 9'(CHUNK - 1);
    state_t           r_state, w_next;
    logic [8:0]       r_ptr, w_sum, w_hi;
    logic [CORES-1:0] r_ack, w_elig, w_gnt;
    logic [IW-1:0]    r_last, w_gnt_idx;
    word_t            r_job_lo, r_job_hi, r_jobs_issued;
    logic             r_exhausted, r_done, w_issue, w_init;
    logic [15:0]      r_run_cycles;
    // a core keeps req high for one cycle after its ack, so mask the core just acked
    assign w_elig = bus.req & ~r_ack;
    assign w_sum  = r_ptr + STEP;
    assign w_hi   = (w_sum > END9) ? END9 : w_sum;
    rr_arbiter #(.N(CORES), .IW(IW)) u_arb (.i_elig(w_elig), .i_last(r_last), .o_gnt(w_gnt));
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < CORES; i++) if (w_gnt[i]) w_gnt_idx = IW'(i);
    end
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_init  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_init = bus.start;
                w_next = bus.start ? DISPATCH : r_state;
            end
            DISPATCH: begin
                w_next  = (r_ptr > END9) ? DRAIN : DISPATCH;
                w_issue = (r_ptr <= END9) && (|w_gnt);
            end
            DRAIN:   w_next = (&bus.req) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // r_last starts at the top index so the first search begins at core 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr         <= '0;
            r_ack         <= '0;
            r_job_lo      <= '0;
            r_job_hi      <= '0;
            r_jobs_issued <= '0;
            r_run_cycles  <= '0;
            r_exhausted   <= 1'b0;
            r_done        <= 1'b0;
            r_last        <= IW'(CORES - 1);
        end else begin
            r_ack <= w_issue ? w_gnt : '0;
            if (w_init) begin
                r_ptr         <= '0;
                r_jobs_issued <= '0;
                r_run_cycles  <= '0;
                r_exhausted   <= 1'b0;
                r_done        <= 1'b0;
            end else begin
                if ((r_state == DISPATCH || r_state == DRAIN) && !(&r_run_cycles)) r_run_cycles <= r_run_cycles + 16'd1;
                if (r_state == DISPATCH && w_next == DRAIN) r_exhausted <= 1'b1;
                if (r_state == DRAIN && w_next == DONE) r_done <= 1'b1;
            end
            if (w_issue) begin
                r_job_lo      <= r_ptr[7:0];
                r_job_hi      <= w_hi[7:0];
                r_ptr         <= w_hi + 9'd1;
                r_jobs_issued <= r_jobs_issued + 8'd1;
                r_last        <= w_gnt_idx;
            end
        end
    end
    assign bus.ack         = r_ack;
    assign bus.job_lo      = r_job_lo;
    assign bus.job_hi      = r_job_hi;
    assign bus.exhausted   = r_exhausted;
    assign bus.done        = r_done;
    assign bus.jobs_issued = r_jobs_issued;
    assign bus.run_cycles  = r_run_cycles;
endmodule

// File: tb/tb_job_dispatcher.sv
// tb_job_dispatcher: directed checks of dispatch order, job ranges, drain/done and reset
module tb_job_dispatcher;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    job_dispatcher_if #(.CORES(4)) bus_a ();
    job_dispatcher_if #(.CORES(4)) bus_b ();
    job_dispatcher #(.CORES(4), .RANGE_END(255), .CHUNK(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    job_dispatcher #(.CORES(4), .RANGE_END(100), .CHUNK(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int drop_at;
        int raise_at;
        logic prev_ack;
        logic [3:0] a;
        bus_a.start = 1'b0; bus_a.req = '0;
        bus_b.start = 1'b0; bus_b.req = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus_a.ack), 0);
        check("rst_lo", 32'(bus_a.job_lo), 0);
        check("rst_hi", 32'(bus_a.job_hi), 0);
        check("rst_exh", 32'(bus_a.exhausted), 0);
        check("rst_done", 32'(bus_a.done), 0);
        check("rst_jobs", 32'(bus_a.jobs_issued), 0);
        check("rst_cyc", 32'(bus_a.run_cycles), 0);
        reset = 1'b1;
        // run 1: all cores idle, full range on A and short range on B
        @(negedge clk);
        bus_a.req = 4'hF; bus_b.req = 4'hF;
        bus_a.start = 1'b1; bus_b.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0; bus_b.start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            check("r1_ack", 32'(bus_a.ack), 32'(1 << (k % 4)));
            check("r1_lo", 32'(bus_a.job_lo), 32'(16 * k));
            check("r1_hi", 32'(bus_a.job_hi), 32'(16 * k + 15));
            if (k < 7) begin
                check("b_ack", 32'(bus_b.ack), 32'(1 << (k % 4)));
                check("b_lo", 32'(bus_b.job_lo), 32'(16 * k));
                check("b_hi", 32'(bus_b.job_hi), (k == 6) ? 32'd100 : 32'(16 * k + 15));
            end
            @(negedge clk);
        end
        check("r1_drain_ack", 32'(bus_a.ack), 0);
        check("r1_exh", 32'(bus_a.exhausted), 1);
        check("r1_done_early", 32'(bus_a.done), 0);
        check("r1_jobs", 32'(bus_a.jobs_issued), 16);
        @(negedge clk);
        check("r1_done", 32'(bus_a.done), 1);
        check("r1_cycles", 32'(bus_a.run_cycles), 18);
        repeat (2) @(negedge clk);
        check("r1_cyc_frozen", 32'(bus_a.run_cycles), 18);
        check("b_jobs", 32'(bus_b.jobs_issued), 7);
        check("b_exh", 32'(bus_b.exhausted), 1);
        check("b_done", 32'(bus_b.done), 1);
        check("b_idle_ack", 32'(bus_b.ack), 0);
        // run 2: restart from DONE, start ignored mid-run, core 1 stays busy into drain
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        @(negedge clk);
        check("r2_ack0", 32'(bus_a.ack), 4'b0001);
        check("r2_lo0", 32'(bus_a.job_lo), 0);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        check("r2_lo1", 32'(bus_a.job_lo), 16);
        @(negedge clk);
        check("r2_lo2", 32'(bus_a.job_lo), 32);
        check("r2_jobs", 32'(bus_a.jobs_issued), 3);
        bus_a.req = 4'b1101;
        for (int i = 0; i < 60 && !bus_a.exhausted; i++) @(negedge clk);
        check("r2_exh", 32'(bus_a.exhausted), 1);
        repeat (3) @(negedge clk);
        check("r2_hold_done", 32'(bus_a.done), 0);
        check("r2_jobs_all", 32'(bus_a.jobs_issued), 16);
        bus_a.req = 4'hF;
        repeat (2) @(negedge clk);
        check("r2_done", 32'(bus_a.done), 1);
        // run 3: only core 2 works, dropping req after each ack and returning later
        bus_a.req = 4'b0100;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        acks = 0; drop_at = -1; raise_at = -1; prev_ack = 1'b0;
        for (int cyc = 0; cyc < 80 && acks < 5; cyc++) begin
            @(negedge clk);
            a = bus_a.ack;
            if (a != 4'b0000) begin
                check("c2_ack", 32'(a), 4'b0100);
                check("c2_no_b2b", 32'(prev_ack), 0);
                acks++;
                drop_at = cyc + 1;
            end
            if (cyc == drop_at) begin bus_a.req = 4'b0000; raise_at = cyc + 5; end
            if (cyc == raise_at) bus_a.req = 4'b0100;
            prev_ack = |a;
        end
        check("c2_count", 32'(acks), 5);
        check("c2_jobs", 32'(bus_a.jobs_issued), 5);
        // reset mid-run, then a fresh run
        reset = 1'b0;
        #1;
        check("mr_ack", 32'(bus_a.ack), 0);
        check("mr_lo", 32'(bus_a.job_lo), 0);
        check("mr_hi", 32'(bus_a.job_hi), 0);
        check("mr_jobs", 32'(bus_a.jobs_issued), 0);
        check("mr_cyc", 32'(bus_a.run_cycles), 0);
        check("mr_exh", 32'(bus_a.exhausted), 0);
        check("mr_done", 32'(bus_a.done), 0);
        @(negedge clk);
        reset = 1'b1;
        bus_a.req = 4'hF;
        @(negedge clk);
        check("post_rst_ack", 32'(bus_a.ack), 0);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(bus_a.ack), 4'b0001);
        check("post_rst_lo", 32'(bus_a.job_lo), 0);
        check("post_rst_hi", 32'(bus_a.job_hi), 15);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
